// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: pixel divider, h/v counters, syncs, video-on, frame tick.
// `define VGA_FRAME_COUNT_EN to add the 8-bit oFrameCount output.
module vga_timing_gen #(
  parameter int   CLK_DIV     = 2,
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  output logic       oPixelTick,
  output logic [9:0] oColumn,
  output logic [9:0] oRow,
  output logic       oVideoOn,
  output logic       oHSync,
  output logic       oVSync,
  output logic       oFrameTick
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] oFrameCount
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    V_VIS    = 10'(V_VISIBLE);
  // Thresholds are 11 bits so a sync or porch edge at 1024 cannot wrap.
  localparam logic [10:0]   H_VIS_E  = 11'(H_VISIBLE);
  localparam logic [10:0]   V_VIS_E  = 11'(V_VISIBLE);
  localparam logic [10:0]   HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0]   HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0]   VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0]   VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic          ptick_q, ptick_d;
  logic [9:0]    col_q, col_d;
  logic [9:0]    row_q, row_d;
  logic          video_q, video_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          ftick_q, ftick_d;

  // Decodes are taken from the next coordinates so every output register
  // always describes the same pixel as oColumn/oRow.
  always_comb begin
    div_d   = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    ptick_d = (div_d == DIV_LAST);
    col_d   = col_q;
    row_d   = row_q;
    if (ptick_q) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        row_d = (row_q == V_LAST) ? '0 : row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
    video_d = ({1'b0, col_d} < H_VIS_E) && ({1'b0, row_d} < V_VIS_E);
    hsync_d = (({1'b0, col_d} >= HS_START) && ({1'b0, col_d} < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d = (({1'b0, row_d} >= VS_START) && ({1'b0, row_d} < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    ftick_d = ptick_q && (col_d == 10'd0) && (row_d == V_VIS);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      div_q   <= '0;
      ptick_q <= 1'b0;
      col_q   <= H_LAST;
      row_q   <= V_LAST;
      video_q <= 1'b0;
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
      ftick_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      ptick_q <= ptick_d;
      col_q   <= col_d;
      row_q   <= row_d;
      video_q <= video_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      ftick_q <= ftick_d;
    end
  end

  assign oPixelTick = ptick_q;
  assign oColumn    = col_q;
  assign oRow       = row_q;
  assign oVideoOn   = video_q;
  assign oHSync     = hsync_q;
  assign oVSync     = vsync_q;
  assign oFrameTick = ftick_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] fcnt_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      fcnt_q <= '0;
    end else if (ftick_q) begin
      fcnt_q <= fcnt_q + 8'd1;
    end
  end

  assign oFrameCount = fcnt_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Upstream raster timing stage for the snake display pipeline. Divides Clock to a pixel rate and runs horizontal/vertical counters. Produces HSYNC/VSYNC, the video-on flag consumed by the RGB colour mapper, and the pixel coordinates consumed by the snake-world and icon pixel generators. Also emits a once-per-frame tick so game logic can update during vertical blanking.

Parameters:
CLK_DIV, 2, Clock cycles per pixel; legal range >=2 (50 MHz in gives 25 MHz pixel rate).
H_VISIBLE, 640, visible columns.
H_FP, 16, horizontal front porch in pixels.
H_SYNC, 96, horizontal sync width in pixels.
H_BP, 48, horizontal back porch in pixels.
V_VISIBLE, 480, visible rows.
V_FP, 10, vertical front porch in lines.
V_SYNC, 2, vertical sync width in lines.
V_BP, 33, vertical back porch in lines.
SYNC_ACTIVE, 0, level of oHSync/oVSync during the sync pulse.

Ports:
Clock  in  1  system clock; all logic on the rising edge.
Reset  in  1  synchronous, active-high reset.
oPixelTick  out  1  one-Clock pulse marking a pixel advance.
oColumn  out  10  current column, 0..H_TOTAL-1.
oRow  out  10  current row, 0..V_TOTAL-1.
oVideoOn  out  1  high iff the current pixel is visible.
oHSync  out  1  horizontal sync.
oVSync  out  1  vertical sync.
oFrameTick  out  1  one-Clock pulse at the start of vertical blanking.

Behaviour:
- Derived totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (default 525). Both must be <=1024; counter width is fixed at 10 bits.
- Divider: div counts 0..CLK_DIV-1 and wraps. oPixelTick = (div==CLK_DIV-1).
- Pixel advance: on each rising edge where oPixelTick=1:
  - If oColumn==H_TOTAL-1, oColumn goes to 0 and the row advances. Otherwise oColumn increments.
  - Row advance: if oRow==V_TOTAL-1, oRow goes to 0. Otherwise oRow increments.
- Outputs are registers and are consistent with (oColumn, oRow) in every cycle:
  - oVideoOn = (oColumn<H_VISIBLE) && (oRow<V_VISIBLE).
  - oHSync = SYNC_ACTIVE iff H_VISIBLE+H_FP <= oColumn < H_VISIBLE+H_FP+H_SYNC (default columns 656..751); otherwise the inverse.
  - oVSync = SYNC_ACTIVE iff V_VISIBLE+V_FP <= oRow < V_VISIBLE+V_FP+V_SYNC (default rows 490..491); otherwise the inverse.
- oFrameTick: high for exactly one Clock cycle, the first cycle in which (oColumn,oRow)==(0,V_VISIBLE). One pulse per frame.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV Clock cycles (840000 at defaults).
- Reset values, taken on the edge where Reset is sampled high:
  - div=0, oPixelTick=0.
  - oColumn=H_TOTAL-1, oRow=V_TOTAL-1 (the last blanking pixel).
  - oVideoOn=0, oHSync=oVSync=!SYNC_ACTIVE, oFrameTick=0.
  - The first pixel advance after reset therefore lands on (0,0).
- Reset held: outputs stay at reset values. Reset mid-frame: the next edge returns all outputs to reset values; no partial pulse is extended.
- Downstream alignment: oVideoOn, oColumn and oRow are mutually aligned. A consumer that registers colour adds its own latency and is responsible for delaying sync to match.

Optional Feature:
Macro VGA_FRAME_COUNT_EN.
- Defined: adds port oFrameCount, out, 8 bits. It increments on the edge where oFrameTick is high, wraps 255->0, and resets to 0. Used for game speed and blink timing.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset sampled high, then released -> oColumn=799, oRow=524, oVideoOn=0, syncs=1 during reset; exactly CLK_DIV=2 edges after release, (0,0) with oVideoOn=1.
- Free-run one line from (0,0) -> oVideoOn falls when oColumn goes 639->640; oHSync=0 exactly for columns 656..751 (96 pixels = 192 Clocks); oColumn wraps 799->0 and oRow increments.
- Free-run a full frame -> oVSync=0 only for rows 490..491; oFrameTick pulses once per 840000 Clocks, one cycle wide, with oColumn=0, oRow=480.
- Wrap corner (799,524) -> next advance gives (0,0) with oVideoOn=1, and no frame tick is emitted.
- Assert Reset for one cycle at (300,200) -> next cycle shows reset values; the following frame timing is identical to a cold start.
- With VGA_FRAME_COUNT_EN, run 257 frames -> oFrameCount reads 1 after wrap; without the macro, the build has no oFrameCount port.
